// File: rtl/reg_file_pkg.sv
// Shared types and constants for the multi-port register file with scoreboard.
package reg_file_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int unsigned RF_ZERO_ADDR = 0;
  localparam int unsigned RF_NRD_MIN   = 1;
  localparam int unsigned RF_NRD_MAX   = 4;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, set wins on collision.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy,
  output logic              waw
);

  logic [DEPTH-1:0] pending;
  logic             set_ok;
  logic             clr_ok;

  assign set_ok = en && set_en && (set_addr != AW'(RF_ZERO_ADDR));
  assign clr_ok = en && clr_en && (clr_addr != AW'(RF_ZERO_ADDR));

  // Set is applied after clear so a new producer overrides a same-cycle writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (clr_ok) pending[clr_addr] <= 1'b0;
      if (set_ok) pending[set_addr] <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      busy[p] = en & pending[rd_addr[p*AW +: AW]];
    end
  end

  assign waw = set_ok && pending[set_addr];

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-read-port register file with pending scoreboard and zeroing sweep after reset.
// Optional same-cycle write-to-read forwarding enabled by REG_FILE_BYPASS_EN.
module reg_file_mp_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 o_ready,
  input  logic [NRD*AW-1:0]    i_rd_addr,
  output logic [NRD*WIDTH-1:0] o_rd_data,
  output logic [NRD-1:0]       o_rd_busy,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic                 i_iss_en,
  input  logic [AW-1:0]        i_iss_addr,
  output logic                 o_iss_waw
);

  if (NRD < RF_NRD_MIN || NRD > RF_NRD_MAX || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("reg_file_mp_sb: unsupported NRD or DEPTH");
  end

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] data [DEPTH];
  logic             ready;
  logic             wr_ok;
  logic [NRD-1:0]   sb_busy;
  logic [AW-1:0]    ra;

  assign ready   = (state == ST_READY) && !rst;
  assign o_ready = ready;
  assign wr_ok   = ready && i_wr_en && (i_wr_addr != AW'(RF_ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  // Storage: zeroing sweep during init, writeback once ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        data[cnt] <= '0;
      end else if (wr_ok) begin
        data[i_wr_addr] <= i_wr_data;
      end
    end
  end

  reg_file_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (ready),
    .set_en   (i_iss_en),
    .set_addr (i_iss_addr),
    .clr_en   (i_wr_en),
    .clr_addr (i_wr_addr),
    .rd_addr  (i_rd_addr),
    .busy     (sb_busy),
    .waw      (o_iss_waw)
  );

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    ra        = '0;
    for (int p = 0; p < int'(NRD); p++) begin
      ra = i_rd_addr[p*AW +: AW];
      if (ready && ra != AW'(RF_ZERO_ADDR)) begin
        o_rd_data[p*WIDTH +: WIDTH] = data[ra];
        o_rd_busy[p]                = sb_busy[p];
`ifdef REG_FILE_BYPASS_EN
        if (wr_ok && i_wr_addr == ra) begin
          o_rd_data[p*WIDTH +: WIDTH] = i_wr_data;
          o_rd_busy[p]                = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Self-checking bench: default 32x32/2-port instance and a 16-entry/4-port instance.
module tb_reg_file_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH 32, DEPTH 32, NRD 2
  logic        rst_a = 1'b1;
  logic        ready_a;
  logic [9:0]  rd_addr_a = '0;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic        wr_en_a = 1'b0;
  logic [4:0]  wr_addr_a = '0;
  logic [31:0] wr_data_a = '0;
  logic        iss_en_a = 1'b0;
  logic [4:0]  iss_addr_a = '0;
  logic        iss_waw_a;

  // Instance B: WIDTH 32, DEPTH 16, NRD 4
  logic         rst_b = 1'b1;
  logic         ready_b;
  logic [15:0]  rd_addr_b = '0;
  logic [127:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic         wr_en_b = 1'b0;
  logic [3:0]   wr_addr_b = '0;
  logic [31:0]  wr_data_b = '0;
  logic         iss_en_b = 1'b0;
  logic [3:0]   iss_addr_b = '0;
  logic         iss_waw_b;

  reg_file_mp_sb #(.WIDTH(32), .DEPTH(32), .NRD(2)) u_dut_a (
    .clk(clk), .rst(rst_a), .o_ready(ready_a),
    .i_rd_addr(rd_addr_a), .o_rd_data(rd_data_a), .o_rd_busy(rd_busy_a),
    .i_wr_en(wr_en_a), .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a),
    .i_iss_en(iss_en_a), .i_iss_addr(iss_addr_a), .o_iss_waw(iss_waw_a)
  );

  reg_file_mp_sb #(.WIDTH(32), .DEPTH(16), .NRD(4)) u_dut_b (
    .clk(clk), .rst(rst_b), .o_ready(ready_b),
    .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
    .i_wr_en(wr_en_b), .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b),
    .i_iss_en(iss_en_b), .i_iss_addr(iss_addr_b), .o_iss_waw(iss_waw_b)
  );

  // Reference models: contents read as zero after reset, usable after DEPTH idle-of-reset cycles.
  logic [31:0] ma_data [32];
  bit          ma_pend [32];
  int          ma_left = 32;
  logic [31:0] mb_data [16];
  bit          mb_pend [16];
  int          mb_left = 16;

  task automatic step_a();
    @(posedge clk);
    if (rst_a) begin
      ma_left = 32;
      for (int i = 0; i < 32; i++) begin ma_data[i] = '0; ma_pend[i] = 0; end
    end else if (ma_left > 0) begin
      ma_left--;
    end else begin
      if (wr_en_a && wr_addr_a != 0) begin ma_data[wr_addr_a] = wr_data_a; ma_pend[wr_addr_a] = 0; end
      if (iss_en_a && iss_addr_a != 0) ma_pend[iss_addr_a] = 1;
    end
    @(negedge clk);
  endtask

  task automatic step_b();
    @(posedge clk);
    if (rst_b) begin
      mb_left = 16;
      for (int i = 0; i < 16; i++) begin mb_data[i] = '0; mb_pend[i] = 0; end
    end else if (mb_left > 0) begin
      mb_left--;
    end else begin
      if (wr_en_b && wr_addr_b != 0) begin mb_data[wr_addr_b] = wr_data_b; mb_pend[wr_addr_b] = 0; end
      if (iss_en_b && iss_addr_b != 0) mb_pend[iss_addr_b] = 1;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] ea_data(int p);
    logic [4:0] a = rd_addr_a[p*5 +: 5];
    if (rst_a || ma_left != 0 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_a && wr_addr_a == a) return wr_data_a;
`endif
    return ma_data[a];
  endfunction

  function automatic logic ea_busy(int p);
    logic [4:0] a = rd_addr_a[p*5 +: 5];
    if (rst_a || ma_left != 0 || a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_a && wr_addr_a == a) return 1'b0;
`endif
    return ma_pend[a];
  endfunction

  function automatic logic [31:0] eb_data(int p);
    logic [3:0] a = rd_addr_b[p*4 +: 4];
    if (rst_b || mb_left != 0 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_b && wr_addr_b == a) return wr_data_b;
`endif
    return mb_data[a];
  endfunction

  function automatic logic eb_busy(int p);
    logic [3:0] a = rd_addr_b[p*4 +: 4];
    if (rst_b || mb_left != 0 || a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_b && wr_addr_b == a) return 1'b0;
`endif
    return mb_pend[a];
  endfunction

  task automatic test_reset();
    int n;
    rst_a = 1'b1; #1;
    checks++;
    if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_a); end
    step_a(); rst_a = 1'b0;
    n = 0;
    while (n < 100) begin #1; if (ready_a) break; n++; step_a(); end
    checks++;
    if (n != 32) begin errors++; $display("FAIL sweep_len1: got %0d cycles want 32", n); end
    // Fill with garbage, then reset and verify the sweep clears everything.
    wr_en_a = 1'b1;
    for (int a = 1; a < 32; a++) begin wr_addr_a = 5'(a); wr_data_a = $urandom | 32'h1; step_a(); end
    wr_en_a = 1'b0;
    rst_a = 1'b1; step_a(); rst_a = 1'b0;
    rd_addr_a = {5'd5, 5'd31};
    n = 0;
    while (n < 100) begin
      #1; if (ready_a) break;
      checks++;
      if (rd_data_a !== '0 || rd_busy_a !== '0 || iss_waw_a !== 1'b0) begin
        errors++; $display("FAIL init_outputs: got data %h busy %b", rd_data_a, rd_busy_a);
      end
      n++; step_a();
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL sweep_len2: got %0d cycles want 32", n); end
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = {5'(31 - a), 5'(a)}; #1;
      checks++;
      if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
        errors++; $display("FAIL cleared x%0d: got data %h busy %b want 0", a, rd_data_a, rd_busy_a);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'hDEADBEEF; step_a(); wr_en_a = 1'b0;
    rd_addr_a = {5'd5, 5'd5}; #1;
    checks++;
    if (rd_data_a !== {2{32'hDEADBEEF}} || rd_busy_a !== 2'b00) begin
      errors++; $display("FAIL rd_x5: got %h busy %b want deadbeef x2 busy 0", rd_data_a, rd_busy_a);
    end
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'h1234; step_a(); wr_en_a = 1'b0;
    rd_addr_a = {5'd0, 5'd0}; #1;
    checks++;
    if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
      errors++; $display("FAIL rd_x0: got %h busy %b want 0", rd_data_a, rd_busy_a);
    end
  endtask

  task automatic test_scoreboard();
    iss_en_a = 1'b1; iss_addr_a = 5'd7; step_a(); iss_en_a = 1'b0;
    rd_addr_a = {5'd7, 5'd7}; #1;
    checks++;
    if (rd_busy_a !== 2'b11) begin errors++; $display("FAIL busy_x7: got %b want 11", rd_busy_a); end
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h55; step_a(); wr_en_a = 1'b0; #1;
    checks++;
    if (rd_busy_a !== 2'b00 || rd_data_a !== {2{32'h55}}) begin
      errors++; $display("FAIL clr_x7: got %h busy %b want 55 busy 0", rd_data_a, rd_busy_a);
    end
    iss_en_a = 1'b1; iss_addr_a = 5'd7; #1;
    checks++;
    if (iss_waw_a !== 1'b0) begin errors++; $display("FAIL waw_first: got %b want 0", iss_waw_a); end
    step_a(); #1;
    checks++;
    if (iss_waw_a !== 1'b1) begin errors++; $display("FAIL waw_second: got %b want 1", iss_waw_a); end
    iss_en_a = 1'b0; #1;
    checks++;
    if (iss_waw_a !== 1'b0) begin errors++; $display("FAIL waw_idle: got %b want 0", iss_waw_a); end
    wr_en_a = 1'b1; wr_addr_a = 5'd7; step_a(); wr_en_a = 1'b0;
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_d;
    logic        exp_b;
    wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'h11; step_a(); wr_en_a = 1'b0;
    iss_en_a = 1'b1; iss_addr_a = 5'd9; step_a();
    wr_en_a = 1'b1; wr_data_a = 32'hA5; rd_addr_a = {5'd9, 5'd9}; #1;
`ifdef REG_FILE_BYPASS_EN
    exp_d = 32'hA5; exp_b = 1'b0;
`else
    exp_d = 32'h11; exp_b = 1'b1;
`endif
    checks++;
    if (rd_data_a[31:0] !== exp_d || rd_busy_a[0] !== exp_b) begin
      errors++; $display("FAIL same_rd_x9: got %h busy %b want %h busy %b", rd_data_a[31:0], rd_busy_a[0], exp_d, exp_b);
    end
    step_a(); wr_en_a = 1'b0; iss_en_a = 1'b0; #1;
    checks++;
    if (rd_data_a[31:0] !== 32'hA5 || rd_busy_a[0] !== 1'b1) begin
      errors++; $display("FAIL same_after_x9: got %h busy %b want a5 busy 1", rd_data_a[31:0], rd_busy_a[0]);
    end
    wr_en_a = 1'b1; wr_addr_a = 5'd9; step_a(); wr_en_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    iss_en_a = 1'b1; iss_addr_a = 5'd3; step_a(); iss_en_a = 1'b0;
    rst_a = 1'b1; step_a(); rst_a = 1'b0;
    // Hammer x1 with writes and issues while the sweep runs; all must be ignored.
    wr_en_a = 1'b1; wr_addr_a = 5'd1; wr_data_a = 32'hFFFF_FFFF;
    iss_en_a = 1'b1; iss_addr_a = 5'd1;
    for (int i = 0; i < 10; i++) step_a();
    rst_a = 1'b1; step_a(); rst_a = 1'b0;
    n = 0;
    while (n < 100) begin
      #1; if (ready_a) break;
      checks++;
      if (iss_waw_a !== 1'b0) begin errors++; $display("FAIL init_waw: got %b want 0", iss_waw_a); end
      n++; step_a();
    end
    wr_en_a = 1'b0; iss_en_a = 1'b0;
    checks++;
    if (n != 32) begin errors++; $display("FAIL sweep_restart: got %0d cycles want 32", n); end
    rd_addr_a = {5'd3, 5'd1}; #1;
    checks++;
    if (rd_data_a !== 64'h0 || rd_busy_a !== 2'b00) begin
      errors++; $display("FAIL mid_reset_state: got %h busy %b want 0 busy 00", rd_data_a, rd_busy_a);
    end
  endtask

  task automatic test_random_a();
    for (int c = 0; c < 400; c++) begin
      wr_en_a    = 1'($urandom_range(0, 1));
      wr_addr_a  = 5'($urandom_range(0, 7));
      wr_data_a  = $urandom;
      iss_en_a   = 1'($urandom_range(0, 1));
      iss_addr_a = 5'($urandom_range(0, 7));
      rd_addr_a  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (rd_data_a[p*32 +: 32] !== ea_data(p) || rd_busy_a[p] !== ea_busy(p)) begin
          errors++; $display("FAIL rand_a c%0d p%0d: got %h/%b want %h/%b", c, p,
                             rd_data_a[p*32 +: 32], rd_busy_a[p], ea_data(p), ea_busy(p));
        end
      end
      checks++;
      if (iss_waw_a !== (iss_en_a && iss_addr_a != 0 && ma_pend[iss_addr_a])) begin
        errors++; $display("FAIL rand_a_waw c%0d: got %b", c, iss_waw_a);
      end
      step_a();
    end
    wr_en_a = 1'b0; iss_en_a = 1'b0;
  endtask

  task automatic test_nrd4();
    int n;
    logic [31:0] v [4];
    step_b(); rst_b = 1'b0;
    n = 0;
    while (n < 100) begin #1; if (ready_b) break; n++; step_b(); end
    checks++;
    if (n != 16) begin errors++; $display("FAIL sweep_b: got %0d cycles want 16", n); end
    v[0] = 32'h1111_0003; v[1] = 32'h2222_0006; v[2] = 32'h3333_000A; v[3] = 32'h4444_000F;
    wr_en_b = 1'b1;
    wr_addr_b = 4'd3;  wr_data_b = v[0]; step_b();
    wr_addr_b = 4'd6;  wr_data_b = v[1]; step_b();
    wr_addr_b = 4'd10; wr_data_b = v[2]; step_b();
    wr_addr_b = 4'd15; wr_data_b = v[3]; step_b();
    wr_en_b = 1'b0;
    rd_addr_b = {4'd15, 4'd10, 4'd6, 4'd3}; #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (rd_data_b[p*32 +: 32] !== v[p] || rd_busy_b[p] !== 1'b0) begin
        errors++; $display("FAIL par_rd p%0d: got %h want %h", p, rd_data_b[p*32 +: 32], v[p]);
      end
    end
    for (int c = 0; c < 300; c++) begin
      wr_en_b    = 1'($urandom_range(0, 1));
      wr_addr_b  = 4'($urandom_range(0, 15));
      wr_data_b  = $urandom;
      iss_en_b   = 1'($urandom_range(0, 1));
      iss_addr_b = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) rd_addr_b[p*4 +: 4] = 4'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (rd_data_b[p*32 +: 32] !== eb_data(p) || rd_busy_b[p] !== eb_busy(p)) begin
          errors++; $display("FAIL rand_b c%0d p%0d: got %h/%b want %h/%b", c, p,
                             rd_data_b[p*32 +: 32], rd_busy_b[p], eb_data(p), eb_busy(p));
        end
      end
      checks++;
      if (iss_waw_b !== (iss_en_b && iss_addr_b != 0 && mb_pend[iss_addr_b])) begin
        errors++; $display("FAIL rand_b_waw c%0d: got %b", c, iss_waw_b);
      end
      step_b();
    end
    wr_en_b = 1'b0; iss_en_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_cycle();
    test_reset_mid();
    test_random_a();
    test_nrd4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
